// File: rtl/fpadd_sched.sv
// fpadd_sched: round-robin scheduler sharing one multi-cycle FP adder among NREQ requesters.
// Optional WAIT-state timeout abort is compiled in when FPADD_SCHED_TIMEOUT_EN is defined.
module fpadd_sched #(
  parameter int NREQ           = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [IDW-1:0]       owner,
  output logic                 fp_start,
  output logic [31:0]          fp_a,
  output logic [31:0]          fp_b,
  input  logic [31:0]          fp_sum,
  input  logic                 fp_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  pick_idx;
  logic            pick_found;
  logic [31:0]     fp_a_q, fp_a_d, fp_b_q, fp_b_d;
  logic [31:0]     rsp_sum_q, rsp_sum_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            wait_first_q, wait_first_d;
  logic [31:0]     a_arr [NREQ];
  logic [31:0]     b_arr [NREQ];

  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("fpadd_sched: IDW must equal clog2(NREQ)");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("fpadd_sched: NREQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("fpadd_sched: TIMEOUT_CYCLES must be positive");
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[32*gi +: 32];
    assign b_arr[gi] = req_b[32*gi +: 32];
  end

`ifdef FPADD_SCHED_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  // Lowest rotational distance from rr_q wins: scan far-to-near so the nearest hit is written last.
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      rr_q         <= '0;
      fp_a_q       <= '0;
      fp_b_q       <= '0;
      rsp_sum_q    <= '0;
      gnt_q        <= '0;
      wait_first_q <= 1'b0;
`ifdef FPADD_SCHED_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      fp_a_q       <= fp_a_d;
      fp_b_q       <= fp_b_d;
      rsp_sum_q    <= rsp_sum_d;
      gnt_q        <= gnt_d;
      wait_first_q <= wait_first_d;
`ifdef FPADD_SCHED_TIMEOUT_EN
      cnt_q        <= cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    fp_a_d       = fp_a_q;
    fp_b_d       = fp_b_q;
    rsp_sum_d    = rsp_sum_q;
    gnt_d        = '0;
    wait_first_d = wait_first_q;
`ifdef FPADD_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          fp_a_d  = a_arr[pick_idx];
          fp_b_d  = b_arr[pick_idx];
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_first_d = 1'b1;
`ifdef FPADD_SCHED_TIMEOUT_EN
        cnt_d        = '0;
`endif
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // fp_done may still reflect the previous operation during the first WAIT cycle.
        wait_first_d = 1'b0;
        if (fp_done && !wait_first_q) begin
          rsp_sum_d = fp_sum;
          state_d   = S_RESP;
`ifdef FPADD_SCHED_TIMEOUT_EN
          rsp_err_d = 1'b0;
        end else if (cnt_q == CNTW'(TIMEOUT_CYCLES)) begin
          rsp_sum_d = 32'h7FC0_0000;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        rr_d    = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
`ifdef FPADD_SCHED_TIMEOUT_EN
        rsp_err_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[owner_q] = 1'b1;
    busy     = (state_q != S_IDLE);
    fp_start = (state_q == S_ISSUE);
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign fp_a    = fp_a_q;
  assign fp_b    = fp_b_q;
  assign rsp_sum = rsp_sum_q;
`ifdef FPADD_SCHED_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpadd_sched.sv
// tb_fpadd_sched: scoreboard bench for fpadd_sched with a behavioural multi-cycle adder model.
// Timeout expectations follow FPADD_SCHED_TIMEOUT_EN, matching the RTL build.
module tb_fpadd_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 8;

  localparam logic [31:0] TAB_A [8] = '{32'h3F800000, 32'h40400000, 32'h40A00000, 32'h3F000000,
                                        32'h41200000, 32'hBF800000, 32'h40E00000, 32'h41100000};
  localparam logic [31:0] TAB_B [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h3F000000,
                                        32'h41A00000, 32'h40000000, 32'h41000000, 32'h41100000};
  localparam logic [31:0] TAB_S [8] = '{32'h40400000, 32'h40E00000, 32'h41300000, 32'h3F800000,
                                        32'h41F00000, 32'h3F800000, 32'h41700000, 32'h41900000};

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [32*NREQ-1:0]  req_a, req_b;
  logic [NREQ-1:0]     gnt, rsp_valid;
  logic [31:0]         rsp_sum, fp_a, fp_b;
  logic                rsp_err, busy, fp_start;
  logic [IDW-1:0]      owner;
  logic [31:0]         fp_sum = '0;
  logic                fp_done = 1'b0;

  always #5 clk = ~clk;

  fpadd_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .busy(busy), .owner(owner), .fp_start(fp_start), .fp_a(fp_a), .fp_b(fp_b),
    .fp_sum(fp_sum), .fp_done(fp_done)
  );

  int op_sel [NREQ] = '{0, 0, 0, 0};
  bit garble [NREQ] = '{0, 0, 0, 0};

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = garble[i] ? 32'hFFFF_FFFF : TAB_A[op_sel[i]];
      req_b[32*i +: 32] = garble[i] ? 32'hFFFF_FFFF : TAB_B[op_sel[i]];
    end
  end

  // Adder model: done is a level that drops on start (or one cycle later with slow_clear).
  int          lat = 10;
  bit          never_done = 1'b0;
  bit          slow_clear = 1'b0;
  int          mcnt = 0;
  bit          clr_pend = 1'b0;
  logic [31:0] pend_sum = '0;

  function automatic logic [31:0] lookup(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++)
      if (TAB_A[i] == a && TAB_B[i] == b) return TAB_S[i];
    return 32'hDEADBEEF;
  endfunction

  always @(posedge clk) begin
    if (fp_start) begin
      pend_sum <= lookup(fp_a, fp_b);
      mcnt     <= never_done ? 0 : lat;
      clr_pend <= slow_clear;
      if (!slow_clear) fp_done <= 1'b0;
    end else begin
      if (clr_pend) begin
        fp_done  <= 1'b0;
        clr_pend <= 1'b0;
      end
      if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          fp_done <= 1'b1;
          fp_sum  <= pend_sum;
        end
      end
    end
  end

  typedef struct {
    int          own;
    logic [31:0] sum;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  int          gnt_log [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_lat = 0;
  int          start_cnt = 0;
  int          rsp_cnt [NREQ] = '{0, 0, 0, 0};
  bit          tmo_mode = 1'b0;
  logic [31:0] exp_fa = '0, exp_fb = '0;

  // Monitor: pushes expectations on each grant, pops and compares on each response.
  always @(negedge clk) begin : mon
    int              g;
    exp_t            e;
    logic [NREQ-1:0] one;
    cyc = cyc + 1;
    g   = 0;
    one = 1;
    if (!reset) begin
      if (gnt != 0) begin
        for (int i = 0; i < NREQ; i++) if (gnt[i]) g = i;
        checks++;
        if (!$onehot(gnt) || fp_start !== 1'b1 || owner !== IDW'(g)) begin
          errors++;
          $display("FAIL grant: gnt=%b fp_start=%b owner=%0d, required one-hot gnt, fp_start=1, owner=%0d",
                   gnt, fp_start, owner, g);
        end
        gnt_log.push_back(g);
        exp_fa = TAB_A[op_sel[g]];
        exp_fb = TAB_B[op_sel[g]];
        sb.push_back('{own: g, sum: (tmo_mode ? 32'h7FC00000 : TAB_S[op_sel[g]]), err: tmo_mode});
      end
      if (fp_start) begin
        start_cnt++;
        start_cyc = cyc;
        checks++;
        if (fp_a !== exp_fa || fp_b !== exp_fb) begin
          errors++;
          $display("FAIL operands: fp_a=%h fp_b=%h, required %h %h", fp_a, fp_b, exp_fa, exp_fb);
        end
      end
      if (rsp_valid != 0) begin
        checks++;
        last_lat = cyc - start_cyc;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=%b sum=%h, required no response", rsp_valid, rsp_sum);
        end else begin
          e = sb.pop_front();
          rsp_cnt[e.own]++;
          if (rsp_valid !== (one << e.own) || rsp_sum !== e.sum || rsp_err !== e.err) begin
            errors++;
            $display("FAIL response: rsp_valid=%b sum=%h err=%b, required %b %h %b",
                     rsp_valid, rsp_sum, rsp_err, one << e.own, e.sum, e.err);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_grants(input int n, input int maxc, output bit ok);
    for (int c = 0; c < maxc && gnt_log.size() < n; c++) tick(1);
    ok = (gnt_log.size() >= n);
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    for (int c = 0; c < maxc && busy !== 1'b0; c++) tick(1);
    ok = (busy === 1'b0);
  endtask

  task automatic wait_rsp(input int idx, input int base, input int maxc, output bit ok);
    for (int c = 0; c < maxc && rsp_cnt[idx] <= base; c++) tick(1);
    ok = (rsp_cnt[idx] > base);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(2);
    sb.delete();
    gnt_log.delete();
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    tick(2);
    checks++;
    if ({gnt, rsp_valid, rsp_sum, rsp_err, busy, owner, fp_start, fp_a, fp_b} !== '0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b rv=%b sum=%h err=%b busy=%b owner=%0d start=%b a=%h b=%h, required all 0",
               gnt, rsp_valid, rsp_sum, rsp_err, busy, owner, fp_start, fp_a, fp_b);
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_single_op();
    bit ok;
    int s0, r0;
    op_sel[0] = 0;
    lat = 10;
    gnt_log.delete();
    s0 = start_cnt;
    r0 = rsp_cnt[0];
    req = 4'b0001;
    wait_rsp(0, r0, 60, ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL single_rsp: no rsp_valid[0] within 60 cycles, required one"); end
    checks++;
    if (start_cnt - s0 !== 1 || gnt_log.size() !== 1) begin
      errors++;
      $display("FAIL single_pulses: starts=%0d grants=%0d, required 1 1", start_cnt - s0, gnt_log.size());
    end
    checks++;
    if (last_lat !== lat + 2) begin
      errors++;
      $display("FAIL single_latency: start-to-rsp=%0d cycles, required %0d", last_lat, lat + 2);
    end
    tick(2);
    checks++;
    if (busy !== 1'b0 || rsp_cnt[0] !== r0 + 1) begin
      errors++;
      $display("FAIL single_after: busy=%b rsp_count=%0d, required 0 %0d", busy, rsp_cnt[0] - r0, 1);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp1 [4] = '{0, 2, 0, 2};
    int exp2 [4] = '{3, 0, 1, 2};
    apply_reset();
    for (int i = 0; i < NREQ; i++) op_sel[i] = i + 1;
    lat = 3;
    req = 4'b0101;
    wait_grants(4, 200, ok);
    req = '0;
    wait_idle(50, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gnt_log.size() <= i || gnt_log[i] !== exp1[i]) begin
        errors++;
        $display("FAIL rr_0101[%0d]: got %0d, required %0d", i, (gnt_log.size() > i) ? gnt_log[i] : -1, exp1[i]);
      end
    end
    gnt_log.delete();
    req = 4'b1111;
    wait_grants(4, 200, ok);
    req = '0;
    wait_idle(50, ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gnt_log.size() <= i || gnt_log[i] !== exp2[i]) begin
        errors++;
        $display("FAIL rr_1111[%0d]: got %0d, required %0d", i, (gnt_log.size() > i) ? gnt_log[i] : -1, exp2[i]);
      end
    end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL rr_drain: %0d responses outstanding, required 0", sb.size()); end
  endtask

  task automatic test_stale_done();
    bit ok;
    int r0;
    op_sel[3]  = 6;
    lat        = 5;
    slow_clear = 1'b1;
    gnt_log.delete();
    r0  = rsp_cnt[3];
    req = 4'b1000;
    wait_rsp(3, r0, 40, ok);
    req = '0;
    checks++;
    if (!ok || last_lat !== lat + 2) begin
      errors++;
      $display("FAIL stale_done: rsp_seen=%b latency=%0d, required 1 %0d", ok, last_lat, lat + 2);
    end
    wait_idle(10, ok);
    slow_clear = 1'b0;
  endtask

  task automatic test_withdraw();
    bit ok;
    int r1, r2;
    op_sel[1] = 7;
    op_sel[2] = 5;
    lat = 6;
    gnt_log.delete();
    r1  = rsp_cnt[1];
    r2  = rsp_cnt[2];
    req = 4'b0110;
    wait_grants(1, 20, ok);
    tick(2);
    req[1]    = 1'b0;
    garble[1] = 1'b1;
    wait_grants(2, 60, ok);
    req[2] = 1'b0;
    wait_idle(40, ok);
    garble[1] = 1'b0;
    checks++;
    if (!ok || gnt_log.size() !== 2 || gnt_log[0] !== 1 || gnt_log[1] !== 2) begin
      errors++;
      $display("FAIL withdraw_order: grants=%0d first=%0d, required 2 grants 1 then 2", gnt_log.size(),
               (gnt_log.size() > 0) ? gnt_log[0] : -1);
    end
    checks++;
    if (rsp_cnt[1] - r1 !== 1 || rsp_cnt[2] - r2 !== 1) begin
      errors++;
      $display("FAIL withdraw_rsp: rsp1=%0d rsp2=%0d, required 1 1", rsp_cnt[1] - r1, rsp_cnt[2] - r2);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int tot;
    op_sel[1] = 0;
    lat = 20;
    gnt_log.delete();
    req = 4'b0010;
    wait_grants(1, 20, ok);
    tick(3);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt, rsp_valid, rsp_sum, rsp_err, busy, owner, fp_start, fp_a, fp_b} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b owner=%0d sum=%h a=%h b=%h rv=%b, required all 0",
               busy, owner, rsp_sum, fp_a, fp_b, rsp_valid);
    end
    req = '0;
    sb.delete();
    tot = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3];
    tick(2);
    reset = 1'b0;
    tick(25);
    checks++;
    if (rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3] !== tot || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: extra responses=%0d busy=%b, required 0 0",
               rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3] - tot, busy);
    end
    op_sel[2] = 4;
    op_sel[3] = 7;
    lat = 4;
    gnt_log.delete();
    req = 4'b1100;
    wait_grants(1, 20, ok);
    req = '0;
    wait_idle(30, ok);
    checks++;
    if (gnt_log.size() !== 1 || gnt_log[0] !== 2 || sb.size() !== 0) begin
      errors++;
      $display("FAIL post_reset_ptr: grants=%0d first=%0d pending=%0d, required 1 grant to 2, 0 pending",
               gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : -1, sb.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int r0;
`ifdef FPADD_SCHED_TIMEOUT_EN
    tmo_mode = 1'b1;
`endif
    never_done = 1'b1;
    op_sel[0]  = 0;
    gnt_log.delete();
    r0  = rsp_cnt[0];
    req = 4'b0001;
    wait_grants(1, 20, ok);
    req = '0;
`ifdef FPADD_SCHED_TIMEOUT_EN
    wait_rsp(0, r0, 40, ok);
    checks++;
    if (!ok || last_lat !== TMO + 2) begin
      errors++;
      $display("FAIL timeout_abort: rsp_seen=%b latency=%0d, required 1 %0d", ok, last_lat, TMO + 2);
    end
    wait_idle(10, ok);
`else
    tick(100);
    checks++;
    if (busy !== 1'b1 || rsp_cnt[0] !== r0) begin
      errors++;
      $display("FAIL no_timeout: busy=%b responses=%0d, required 1 0", busy, rsp_cnt[0] - r0);
    end
    apply_reset();
`endif
    never_done = 1'b0;
    tmo_mode   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_stale_done();
    test_withdraw();
    test_reset_mid_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpadd_sched.md
Name: fpadd_sched

Overview:
- Round-robin scheduler that shares one multi-cycle floating-point adder among NREQ requesters.
- Latches the winner's operands and pulses the adder's start input.
- Waits for the adder's done, then returns the 32-bit sum to the owning requester with a one-cycle valid pulse.
- Sits between the requester ports and the single adder instance; one operation is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of owner index, must equal clog2(NREQ)
- TIMEOUT_CYCLES, 64, max WAIT cycles before abort; used only with FPADD_SCHED_TIMEOUT_EN

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request level; operands held valid while high
- req_a  in  32*NREQ  operand A, requester i at bits [32i+31:32i]
- req_b  in  32*NREQ  operand B, same packing
- gnt  out  NREQ  one-hot pulse, one cycle, when requester's operands are latched
- rsp_valid  out  NREQ  one-hot pulse, one cycle, result for that requester
- rsp_sum  out  32  result word, valid while any rsp_valid bit high
- rsp_err  out  1  high with rsp_valid when op aborted by timeout; 0 when macro absent
- busy  out  1  high in any state other than IDLE
- owner  out  IDW  index of current/last owner
- fp_start  out  1  start pulse to adder
- fp_a  out  32  operand A to adder, held stable from ISSUE until next ISSUE
- fp_b  out  32  operand B to adder, same
- fp_sum  in  32  adder result
- fp_done  in  1  adder completion level; stays high until next start

Behaviour:
- Reset (async assert, sync release) forces: state=IDLE, gnt=0, rsp_valid=0, rsp_sum=0, rsp_err=0, busy=0, owner=0, fp_start=0, fp_a=0, fp_b=0, rr pointer=0.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, pick the first set bit searching from the rr pointer upward, wrapping at NREQ.
  - Latch that requester's index into owner and its operands into fp_a/fp_b.
  - Pulse gnt[owner] this edge, then go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE: fp_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - fp_done is ignored on the first WAIT cycle, because done may still show the stale value from the previous op.
  - From the second WAIT cycle, fp_done=1 captures fp_sum into rsp_sum and moves to RESP.
- RESP:
  - rsp_valid[owner]=1 for one cycle.
  - rr pointer = owner+1, wrapping NREQ-1 -> 0.
  - Go to IDLE.
- Latency: req seen in IDLE at cycle 0; gnt at edge 0; fp_start high in cycle 1; rsp_valid one cycle after fp_done is sampled.
- Minimum turnaround is 4 cycles plus the adder latency.
- req is sampled only in IDLE:
  - A requester must drop req no later than the cycle after its rsp_valid, or it is re-eligible.
  - Under rr it is served again only after the other pending requesters.
- req dropped while its op is in flight: the op completes and rsp_valid still pulses; the requester ignores it.
- Operand changes after gnt have no effect; fp_a/fp_b come from internal registers.
- Simultaneous requests: exactly one gnt bit per grant; no requester waits more than NREQ-1 other operations.
- Reset mid-operation: abort immediately, no rsp_valid. The adder is not reset by this block; its next start restarts it cleanly.
- rsp_sum holds its value until the next capture; only rsp_valid qualifies it.

Optional Feature:
- Macro: FPADD_SCHED_TIMEOUT_EN.
- Defined:
  - A WAIT counter (clog2(TIMEOUT_CYCLES)+1 bits) clears on ISSUE and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without fp_done: rsp_sum=32'h7FC00000, rsp_err=1 during RESP, then normal rr advance.
- Undefined: no counter; WAIT waits indefinitely; rsp_err tied 0.

Test Plan:
- Single op: req[0]=1, a=32'h3F800000, b=32'h40000000, adder model done after 10 cycles -> gnt[0] pulse, one fp_start pulse, rsp_valid[0] pulse with rsp_sum=32'h40400000, busy low after.
- Round-robin fairness: req=4'b0101 held, pointer 0 -> grants 0, 2, 0, 2. Then req=4'b1111 after owner 2 -> order 3, 0, 1, 2.
- Stale done: adder model holds fp_done=1 through ISSUE and clears it on start, result after 5 cycles -> rsp_valid only after the new done, sum matches the new operands.
- Requester withdraws: req[1] dropped 2 cycles after gnt[1] -> rsp_valid[1] still pulses once; next grant goes to next pending requester.
- Reset mid-WAIT: assert reset asynchronously (between clock edges) 3 cycles into WAIT -> all outputs 0 immediately, no rsp_valid. After release a new req[2] is served normally with pointer at 0.
- Timeout (macro on, TIMEOUT_CYCLES=8): adder never asserts done -> rsp_valid[owner] on the 9th-10th WAIT cycle boundary with rsp_sum=32'h7FC00000, rsp_err=1. With macro off -> still in WAIT after 100 cycles.
